// File: rtl/usbf_ep_pkg.sv
// Shared constants for the USB function endpoint register bank:
// register offsets, CSR/INT field positions, endpoint types, interrupt bits, arbiter states.
package usbf_ep_pkg;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_INT  = 2'd1;
  localparam logic [1:0] REG_BUF0 = 2'd2;
  localparam logic [1:0] REG_BUF1 = 2'd3;

  localparam int CSR_UC_LSB   = 28;
  localparam int CSR_WR_MSB   = 27;
  localparam int CSR_TYPE_MSB = 27;
  localparam int CSR_TYPE_LSB = 26;
  localparam int CSR_EPN_MSB  = 21;
  localparam int CSR_EPN_LSB  = 18;
  localparam int CSR_DMA_EN   = 15;
  localparam int CSR_MPS_MSB  = 10;

  localparam logic [1:0] EP_TYPE_DIS = 2'b00;
  localparam logic [1:0] EP_TYPE_IN  = 2'b01;
  localparam logic [1:0] EP_TYPE_OUT = 2'b10;

  localparam int INT_IENA_LSB = 24;
  localparam int INT_IENB_LSB = 16;

  localparam int INT_TMOUT     = 0;
  localparam int INT_CRC16     = 1;
  localparam int INT_UPID      = 2;
  localparam int INT_BUF0      = 3;
  localparam int INT_BUF1      = 4;
  localparam int INT_OUT_SHORT = 5;
  localparam int INT_SEQERR    = 6;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } arb_state_t;

  // Folds the seven status bits onto the six enable bits; both buffer sources share one enable.
  function automatic logic [5:0] int_map(input logic [6:0] stat);
    return {stat[INT_SEQERR], stat[INT_OUT_SHORT], stat[INT_BUF0] | stat[INT_BUF1],
            stat[INT_UPID], stat[INT_CRC16], stat[INT_TMOUT]};
  endfunction

endpackage

// File: rtl/usbf_ep_rf_bank_if.sv
// Register-access port of the endpoint register bank (decoder side is master).
interface usbf_ep_rf_bank_if #(
  parameter int EAW = 2
) ();
  logic [EAW+1:0] adr;
  logic           re;
  logic           we;
  logic [31:0]    din;
  logic [31:0]    dout;

  modport master (output adr, output re, output we, output din, input dout);
  modport slave  (input adr, input re, input we, input din, output dout);
endinterface

// File: rtl/usbf_ep_dma_arb.sv
// Round-robin DMA request arbiter over the endpoint pending flags (IDLE/REQ FSM).
module usbf_ep_dma_arb
  import usbf_ep_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int EAW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_EP-1:0] pend,
  input  logic              dma_ack,
  output logic              dma_req,
  output logic [EAW-1:0]    dma_ep,
  output logic              ack_pulse
);

  arb_state_t     state_r;
  logic [EAW-1:0] last_r;
  logic [EAW-1:0] grant_s;
  logic [EAW-1:0] cand_s [NUM_EP];

  // Candidate i is the (i+1)-th endpoint after the last serviced one.
  for (genvar i = 0; i < NUM_EP; i++) begin : g_cand
    assign cand_s[i] = EAW'((int'(last_r) + i + 1) % NUM_EP);
  end

  // Pick the nearest pending candidate; scanning downwards lets the nearest one win.
  always_comb begin
    grant_s = last_r;
    for (int i = NUM_EP - 1; i >= 0; i--) begin
      grant_s = pend[cand_s[i]] ? cand_s[i] : grant_s;
    end
  end

  assign ack_pulse = (state_r == ARB_REQ) && dma_ack;

  // Arbiter FSM with registered request and endpoint outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ARB_IDLE;
      dma_req <= 1'b0;
      dma_ep  <= {EAW{1'b0}};
      last_r  <= EAW'(NUM_EP - 1);
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (|pend) begin
            state_r <= ARB_REQ;
            dma_req <= 1'b1;
            dma_ep  <= grant_s;
          end
        end
        ARB_REQ: begin
          if (dma_ack) begin
            state_r <= ARB_IDLE;
            dma_req <= 1'b0;
            last_r  <= dma_ep;
          end else if (!pend[dma_ep]) begin
            // Request withdrawn because DMA was disabled on that endpoint.
            state_r <= ARB_IDLE;
            dma_req <= 1'b0;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          dma_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/usbf_ep_rf_bank.sv
// Bank of NUM_EP endpoint register sets (CSR/INT/BUF0/BUF1) with endpoint match and interrupts.
// Define USBF_EP_DMA_EN to build the DMA pending flags and round-robin request arbiter.
module usbf_ep_rf_bank
  import usbf_ep_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int EAW    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
  input  logic            clk,
  input  logic            rst,
  usbf_ep_rf_bank_if.slave rf,
  output logic            inta,
  output logic            intb,
  input  logic [3:0]      ep_sel,
  output logic            ep_hit,
  output logic [EAW-1:0]  ep_idx,
  output logic [31:0]     csr,
  output logic [31:0]     buf0,
  output logic [31:0]     buf1,
  input  logic [31:0]     idin,
  input  logic            buf0_set,
  input  logic            buf1_set,
  input  logic            buf0_rl,
  input  logic            uc_set,
  input  logic [6:0]      int_set,
  output logic            dma_req,
  output logic [EAW-1:0]  dma_ep,
  input  logic            dma_ack
);

  logic [EAW-1:0]    a_ep_s;
  logic [1:0]        a_reg_s;
  logic [31:0]       csr_a  [NUM_EP];
  logic [31:0]       intr_a [NUM_EP];
  logic [31:0]       buf0_a [NUM_EP];
  logic [31:0]       buf1_a [NUM_EP];
  logic [NUM_EP-1:0] match_s;
  logic [NUM_EP-1:0] ia_s;
  logic [NUM_EP-1:0] ib_s;
  logic [EAW-1:0]    idx_s;
  logic [31:0]       rd_s;

  assign a_ep_s  = rf.adr[EAW+1:2];
  assign a_reg_s = rf.adr[1:0];

`ifdef USBF_EP_DMA_EN
  logic [NUM_EP-1:0] pend_s;
  logic              ack_s;

  usbf_ep_dma_arb #(.NUM_EP(NUM_EP), .EAW(EAW)) u_dma_arb (
    .clk       (clk),
    .rst       (rst),
    .pend      (pend_s),
    .dma_ack   (dma_ack),
    .dma_req   (dma_req),
    .dma_ep    (dma_ep),
    .ack_pulse (ack_s)
  );
`else
  logic unused_dma_s;
  assign dma_req      = 1'b0;
  assign dma_ep       = {EAW{1'b0}};
  assign unused_dma_s = dma_ack;
`endif

  for (genvar e = 0; e < NUM_EP; e++) begin : g_ep
    logic [31:0] csr_r;
    logic [31:0] buf0_r;
    logic [31:0] buf1_r;
    logic [31:0] orig_r;
    logic [5:0]  iena_r;
    logic [5:0]  ienb_r;
    logic [6:0]  stat_r;
    logic        sel_s;
    logic        upd_s;
    logic        clr_s;

    assign sel_s = (int'(a_ep_s) == e);
    assign upd_s = ep_hit && (int'(ep_idx) == e);
    assign clr_s = rf.re && sel_s && (a_reg_s == REG_INT);

    // Register storage; a same-cycle register write takes precedence over internal updates.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        csr_r  <= 32'd0;
        iena_r <= 6'd0;
        ienb_r <= 6'd0;
        stat_r <= 7'd0;
        buf0_r <= 32'hFFFF_FFFF;
        buf1_r <= 32'hFFFF_FFFF;
        orig_r <= 32'hFFFF_FFFF;
      end else begin
        if (rf.we && sel_s && (a_reg_s == REG_CSR)) begin
          csr_r[CSR_WR_MSB:0] <= rf.din[CSR_WR_MSB:0];
        end
        if (upd_s && uc_set) begin
          csr_r[31:CSR_UC_LSB] <= idin[3:0];
        end
        if (rf.we && sel_s && (a_reg_s == REG_INT)) begin
          iena_r <= rf.din[INT_IENA_LSB+5:INT_IENA_LSB];
          ienb_r <= rf.din[INT_IENB_LSB+5:INT_IENB_LSB];
        end
        stat_r <= (clr_s ? 7'd0 : stat_r) | (upd_s ? int_set : 7'd0);
        if (rf.we && sel_s && (a_reg_s == REG_BUF0)) begin
          buf0_r <= rf.din;
          orig_r <= rf.din;
        end else if (upd_s && buf0_rl) begin
          buf0_r <= orig_r;
        end else if (upd_s && buf0_set) begin
          buf0_r <= idin;
        end
        if (rf.we && sel_s && (a_reg_s == REG_BUF1)) begin
          buf1_r <= rf.din;
        end else if (upd_s && buf1_set) begin
          buf1_r <= idin;
        end
      end
    end

`ifdef USBF_EP_DMA_EN
    logic pend_r;

    // Pending flag: dropping dma_en wins, then a new buffer event, then the acknowledge.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pend_r <= 1'b0;
      end else if (!csr_r[CSR_DMA_EN]) begin
        pend_r <= 1'b0;
      end else if (upd_s && (buf0_set || buf0_rl)) begin
        pend_r <= 1'b1;
      end else if (ack_s && (int'(dma_ep) == e)) begin
        pend_r <= 1'b0;
      end
    end

    assign pend_s[e] = pend_r && csr_r[CSR_DMA_EN];
`endif

    assign csr_a[e]   = csr_r;
    assign buf0_a[e]  = buf0_r;
    assign buf1_a[e]  = buf1_r;
    assign intr_a[e]  = {2'b00, iena_r, 2'b00, ienb_r, 9'd0, stat_r};
    assign match_s[e] = (csr_r[CSR_TYPE_MSB:CSR_TYPE_LSB] != EP_TYPE_DIS) &&
                        (csr_r[CSR_EPN_MSB:CSR_EPN_LSB] == ep_sel);
    assign ia_s[e]    = |(iena_r & int_map(stat_r));
    assign ib_s[e]    = |(ienb_r & int_map(stat_r));
  end

  // Lowest matching index wins, so scan from the top down.
  always_comb begin
    idx_s = {EAW{1'b0}};
    for (int i = NUM_EP - 1; i >= 0; i--) begin
      idx_s = match_s[i] ? EAW'(i) : idx_s;
    end
  end

  // Registered match result and aggregated interrupt lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ep_hit <= 1'b0;
      ep_idx <= {EAW{1'b0}};
      inta   <= 1'b0;
      intb   <= 1'b0;
    end else begin
      ep_hit <= |match_s;
      ep_idx <= idx_s;
      inta   <= |ia_s;
      intb   <= |ib_s;
    end
  end

  // Combinational register read mux.
  always_comb begin
    rd_s = 32'd0;
    if (int'(a_ep_s) < NUM_EP) begin
      case (a_reg_s)
        REG_CSR:  rd_s = csr_a[a_ep_s];
        REG_INT:  rd_s = intr_a[a_ep_s];
        REG_BUF0: rd_s = buf0_a[a_ep_s];
        REG_BUF1: rd_s = buf1_a[a_ep_s];
        default:  rd_s = 32'd0;
      endcase
    end else begin
      rd_s = 32'd0;
    end
  end

  assign rf.dout = rd_s;
  assign csr     = csr_a[ep_idx];
  assign buf0    = buf0_a[ep_idx];
  assign buf1    = buf1_a[ep_idx];

endmodule

// File: tb/tb_usbf_ep_rf_bank.sv
// Scoreboard bench for usbf_ep_rf_bank; DMA scenarios follow USBF_EP_DMA_EN.
module tb_usbf_ep_rf_bank;

  logic        clk;
  logic        rst;
  logic        inta, intb, ep_hit, dma_req, dma_ack;
  logic [3:0]  ep_sel;
  logic [1:0]  ep_idx, dma_ep;
  logic [31:0] csr, buf0, buf1, idin;
  logic        buf0_set, buf1_set, buf0_rl, uc_set;
  logic [6:0]  int_set;

  int          vectors;
  int          miscompares;
  logic [31:0] sb_q [$];
  logic [31:0] got, exp;

  usbf_ep_rf_bank_if #(.EAW(2)) rf_if ();

  usbf_ep_rf_bank #(.NUM_EP(4)) dut (
    .clk(clk), .rst(rst), .rf(rf_if), .inta(inta), .intb(intb),
    .ep_sel(ep_sel), .ep_hit(ep_hit), .ep_idx(ep_idx),
    .csr(csr), .buf0(buf0), .buf1(buf1), .idin(idin),
    .buf0_set(buf0_set), .buf1_set(buf1_set), .buf0_rl(buf0_rl), .uc_set(uc_set),
    .int_set(int_set), .dma_req(dma_req), .dma_ep(dma_ep), .dma_ack(dma_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ep, input logic [1:0] r, input logic [31:0] d);
    rf_if.adr = {ep, r};
    rf_if.din = d;
    rf_if.we  = 1'b1;
    tick();
    rf_if.we  = 1'b0;
  endtask

  task automatic peek(input logic [1:0] ep, input logic [1:0] r, output logic [31:0] d);
    rf_if.adr = {ep, r};
    #1;
    d = rf_if.dout;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    for (int e = 0; e < 4; e++) begin
      for (int r = 0; r < 4; r++) begin
        sb_q.push_back((r >= 2) ? 32'hFFFF_FFFF : 32'h0000_0000);
        peek(2'(e), 2'(r), got);
        exp = sb_q.pop_front();
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL reset_reg ep%0d r%0d: got %h want %h", e, r, got, exp);
        end
        tick();
      end
    end
    sb_q.push_back(32'h0);
    got = {28'd0, inta, intb, dma_req, ep_hit};
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_outs {inta,intb,dma_req,ep_hit}: got %h want %h", got, exp);
    end
  endtask

  task automatic test_match();
    wr(2'd1, 2'd0, 32'h0814_0000);
    wr(2'd2, 2'd0, 32'h0814_0000);
    ep_sel = 4'd5;
    sb_q.push_back({30'd0, 1'b1, 1'b1});
    tick();
    got = {29'd0, ep_hit, ep_idx};
    exp = {29'd0, sb_q.pop_front()};
    exp = {29'd0, exp[1], 2'd1};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL match_lowest {hit,idx}: got %h want %h", got, exp);
    end
    wr(2'd1, 2'd0, 32'hF814_0000);
    sb_q.push_back(32'h0814_0000);
    peek(2'd1, 2'd0, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL csr_ro_bits: got %h want %h", got, exp);
    end
    idin   = 32'h0000_000A;
    uc_set = 1'b1;
    sb_q.push_back(32'hA814_0000);
    tick();
    uc_set = 1'b0;
    exp = sb_q.pop_front();
    vectors++;
    if (csr !== exp) begin
      miscompares++;
      $display("FAIL uc_set_csr_port: got %h want %h", csr, exp);
    end
    ep_sel = 4'd7;
    sb_q.push_back(32'h0);
    tick();
    exp = sb_q.pop_front();
    vectors++;
    if ({31'd0, ep_hit} !== exp) begin
      miscompares++;
      $display("FAIL no_match: got %h want %h", ep_hit, exp);
    end
  endtask

  task automatic test_int();
    wr(2'd0, 2'd0, 32'h040C_0000);
    wr(2'd0, 2'd1, 32'h0800_0000);
    ep_sel = 4'd3;
    tick();
    int_set = 7'h10;
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h0800_0010);
    sb_q.push_back(32'h1);
    tick();
    int_set = 7'h00;
    exp = sb_q.pop_front();
    vectors++;
    if ({31'd0, inta} !== exp) begin
      miscompares++;
      $display("FAIL inta_one_edge: got %h want %h", inta, exp);
    end
    peek(2'd0, 2'd1, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL int_stat_set: got %h want %h", got, exp);
    end
    tick();
    exp = sb_q.pop_front();
    vectors++;
    if ({31'd0, inta} !== exp) begin
      miscompares++;
      $display("FAIL inta_two_edges: got %h want %h", inta, exp);
    end
    // Clear-on-read and a new set on the same edge: the set survives.
    rf_if.adr = {2'd0, 2'd1};
    rf_if.re  = 1'b1;
    int_set   = 7'h01;
    sb_q.push_back(32'h0800_0001);
    sb_q.push_back(32'h0800_0000);
    tick();
    rf_if.re = 1'b0;
    int_set  = 7'h00;
    peek(2'd0, 2'd1, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL int_set_beats_clear: got %h want %h", got, exp);
    end
    rf_if.re = 1'b1;
    tick();
    rf_if.re = 1'b0;
    peek(2'd0, 2'd1, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL int_clear_on_read: got %h want %h", got, exp);
    end
    wr(2'd0, 2'd1, 32'h0801_0000);
    int_set = 7'h01;
    sb_q.push_back(32'h1);
    tick();
    int_set = 7'h00;
    tick();
    exp = sb_q.pop_front();
    vectors++;
    if ({30'd0, intb, inta} !== {exp[30:0], 1'b0}) begin
      miscompares++;
      $display("FAIL intb_route {intb,inta}: got %h want %h", {intb, inta}, {exp[0], 1'b0});
    end
  endtask

  task automatic test_buf();
    wr(2'd0, 2'd2, 32'h1234_5678);
    idin     = 32'h0;
    buf0_set = 1'b1;
    sb_q.push_back(32'h0);
    tick();
    buf0_set = 1'b0;
    exp = sb_q.pop_front();
    vectors++;
    if (buf0 !== exp) begin
      miscompares++;
      $display("FAIL buf0_set_port: got %h want %h", buf0, exp);
    end
    buf0_rl = 1'b1;
    sb_q.push_back(32'h1234_5678);
    tick();
    buf0_rl = 1'b0;
    peek(2'd0, 2'd2, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL buf0_reload: got %h want %h", got, exp);
    end
    rf_if.adr = {2'd0, 2'd2};
    rf_if.din = 32'hCAFE_F00D;
    rf_if.we  = 1'b1;
    buf0_set  = 1'b1;
    idin      = 32'h1111_1111;
    sb_q.push_back(32'hCAFE_F00D);
    tick();
    rf_if.we = 1'b0;
    buf0_set = 1'b0;
    peek(2'd0, 2'd2, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL write_beats_set: got %h want %h", got, exp);
    end
    idin     = 32'h0;
    buf0_set = 1'b1;
    tick();
    idin    = 32'h0000_0077;
    buf0_rl = 1'b1;
    sb_q.push_back(32'hCAFE_F00D);
    tick();
    buf0_set = 1'b0;
    buf0_rl  = 1'b0;
    peek(2'd0, 2'd2, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL rl_beats_set: got %h want %h", got, exp);
    end
    idin     = 32'h5555_AAAA;
    buf1_set = 1'b1;
    sb_q.push_back(32'h5555_AAAA);
    sb_q.push_back(32'hFFFF_FFFF);
    tick();
    buf1_set = 1'b0;
    peek(2'd0, 2'd3, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp || buf1 !== exp) begin
      miscompares++;
      $display("FAIL buf1_set: got %h/%h want %h", got, buf1, exp);
    end
    peek(2'd2, 2'd2, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL unmatched_buf0: got %h want %h", got, exp);
    end
  endtask

`ifdef USBF_EP_DMA_EN
  task automatic test_dma();
    int grants;
    int need;
    int idle;
    wr(2'd0, 2'd0, 32'h040C_8000);
    wr(2'd3, 2'd0, 32'h0824_8000);
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) begin
        ep_sel = 4'd3;
        tick();
        buf0_set = 1'b1;
        sb_q.push_back(32'd0);
        tick();
        buf0_set = 1'b0;
        vectors++;
        if (dma_req !== 1'b0) begin
          miscompares++;
          $display("FAIL dma_latency: got %b want 0", dma_req);
        end
        ep_sel = 4'd9;
        tick();
        buf0_set = 1'b1;
        sb_q.push_back(32'd3);
        tick();
        buf0_set = 1'b0;
        need = 2;
      end else begin
        buf0_set = 1'b1;
        sb_q.push_back(32'd3);
        tick();
        buf0_set = 1'b0;
        need = 1;
      end
      grants = 0;
      idle   = 0;
      for (int c = 0; c < 20 && grants < need; c++) begin
        if (dma_req) begin
          exp = sb_q.pop_front();
          vectors++;
          if ({30'd0, dma_ep} !== exp) begin
            miscompares++;
            $display("FAIL dma_grant ph%0d: got %0d want %0d", ph, dma_ep, exp);
          end
          if (ph == 0 && grants == 1) begin
            vectors++;
            if (idle != 1) begin
              miscompares++;
              $display("FAIL dma_idle_gap: got %0d want 1", idle);
            end
          end
          grants++;
          dma_ack = 1'b1;
          tick();
          dma_ack = 1'b0;
          idle = 0;
        end else begin
          idle++;
          tick();
        end
      end
      vectors++;
      if (grants != need) begin
        miscompares++;
        $display("FAIL dma_timeout ph%0d: got %0d grants want %0d", ph, grants, need);
      end
    end
    tick();
    tick();
    vectors++;
    if (dma_req !== 1'b0) begin
      miscompares++;
      $display("FAIL dma_quiet: got %b want 0", dma_req);
    end
  endtask

  task automatic test_dma_abort();
    ep_sel = 4'd3;
    tick();
    buf0_set = 1'b1;
    tick();
    buf0_set = 1'b0;
    sb_q.push_back(32'h1);
    for (int c = 0; c < 5 && !dma_req; c++) tick();
    exp = sb_q.pop_front();
    vectors++;
    if ({31'd0, dma_req} !== exp) begin
      miscompares++;
      $display("FAIL abort_req_rise: got %b want %h", dma_req, exp);
    end
    wr(2'd0, 2'd0, 32'h040C_0000);
    tick();
    vectors++;
    if (dma_req !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_req_drop: got %b want 0", dma_req);
    end
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    wr(2'd0, 2'd0, 32'h040C_8000);
    tick();
    tick();
    vectors++;
    if (dma_req !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pend_cleared: got %b want 0", dma_req);
    end
    buf0_set = 1'b1;
    tick();
    buf0_set = 1'b0;
    for (int c = 0; c < 5 && !dma_req; c++) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({dma_req, dma_ep} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_req: got %b want 000", {dma_req, dma_ep});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask
`else
  task automatic test_dma_off();
    wr(2'd0, 2'd0, 32'h040C_8000);
    sb_q.push_back(32'h040C_8000);
    peek(2'd0, 2'd0, got);
    exp = sb_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL dma_en_storage: got %h want %h", got, exp);
    end
    ep_sel = 4'd3;
    tick();
    buf0_set = 1'b1;
    tick();
    buf0_set = 1'b0;
    for (int c = 0; c < 4; c++) begin
      dma_ack = c[0];
      tick();
      vectors++;
      if ({dma_req, dma_ep} !== 3'b000) begin
        miscompares++;
        $display("FAIL dma_tied_off c%0d: got %b want 000", c, {dma_req, dma_ep});
      end
    end
    dma_ack = 1'b0;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    rf_if.adr   = 4'd0;
    rf_if.re    = 1'b0;
    rf_if.we    = 1'b0;
    rf_if.din   = 32'd0;
    ep_sel      = 4'd0;
    idin        = 32'd0;
    buf0_set    = 1'b0;
    buf1_set    = 1'b0;
    buf0_rl     = 1'b0;
    uc_set      = 1'b0;
    int_set     = 7'd0;
    dma_ack     = 1'b0;
    test_reset();
    test_match();
    test_int();
    test_buf();
`ifdef USBF_EP_DMA_EN
    test_dma();
    test_dma_abort();
`else
    test_dma_off();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usbf_ep_rf_bank.md
# usbf_ep_rf_bank

Parametrised bank of `NUM_EP` USB function endpoint register sets behind one register-access port. It provides:
- per-endpoint CSR, interrupt, BUF0 and BUF1 registers;
- a registered endpoint-match lookup for the protocol engine;
- clear-on-read interrupt status with set-priority;
- an optional round-robin DMA request arbiter.

It sits between the register-access decoder and the protocol engine, replacing one-register-file-per-endpoint instantiation.

## Interface
- `NUM_EP`, 4, number of endpoint register sets (1..16)
- `EAW`, `$clog2(NUM_EP)` (min 1), endpoint index width
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `adr`  in  EAW+2  register address; `{ep, reg}`, where reg 0=CSR, 1=INT, 2=BUF0, 3=BUF1
- `re`, `we`  in  1  register read / write strobes
- `din`  in  32  write data
- `dout`  out  32  read data, combinational on `adr`
- `inta`, `intb`  out  1  aggregated interrupt lines (registered)
- `ep_sel`  in  4  endpoint number from the current token
- `ep_hit`  out  1  registered: an enabled endpoint matched `ep_sel`
- `ep_idx`  out  EAW  registered index of the matched endpoint
- `csr`, `buf0`, `buf1`  out  32  registers of endpoint `ep_idx`
- `idin`  in  32  internal write data
- `buf0_set`, `buf1_set`, `buf0_rl`, `uc_set`  in  1  internal updates to the matched endpoint
- `int_set`  in  7  interrupt sources, bits [6:0]
- `dma_req`  out  1  DMA request
- `dma_ep`  out  EAW  endpoint being serviced
- `dma_ack`  in  1  DMA acknowledge, one-cycle pulse

## Operation
**CSR layout**
- [31:30] `uc_bsel` and [29:28] `uc_dpd` are read-only; `uc_set` loads them from `idin[3:0]`.
- [27:26] type: 00 disabled, 01 IN, 10 OUT.
- [21:18] endpoint number.
- [15] `dma_en`.
- [10:0] `max_pl_sz`.
- A write to CSR updates [27:0] only.

**INT layout**
- [29:24] `iena`, [21:16] `ienb`, [6:0] `int_stat`.
- A write updates the enables only.

**Endpoint match**
- An endpoint matches when its type ≠ 00 and its CSR[21:18] equals `ep_sel`.
- If several match, the lowest index wins.
- The result is registered into `ep_hit` / `ep_idx`.

**Internal updates** (apply only when `ep_hit`, and only to endpoint `ep_idx`)
- BUF0 priority: `buf0_rl` (reload from `buf0_orig`) beats `buf0_set` (load `idin`).
- `buf0_orig` is loaded only by a register write to BUF0.
- `buf1_set` loads `idin` into BUF1.
- A register write to the same register in the same cycle beats any internal update.

**Interrupts**
- `int_stat[i]` is sticky and is set by `int_set[i]`.
- A read (`re`) of INT clears that endpoint's `int_stat` on the next edge.
- If a set and the clear land on the same edge, the set wins.
- Per endpoint, the enable-to-status map for both lines is: `en[0..2]` → `stat[0..2]`, `en[3]` → `stat[3]|stat[4]`, `en[4]` → `stat[5]`, `en[5]` → `stat[6]`.
- `inta` is the OR over all endpoints of the `iena` products; `intb` likewise with `ienb`.

**DMA pending flags**
- `pend[e]` is set by `buf0_set` or `buf0_rl` on a matched endpoint with `dma_en=1`.
- `pend[e]` is cleared by `dma_ack` while `dma_ep=e`; if a set arrives in the same cycle, the set wins.
- Clearing `dma_en` clears `pend[e]` immediately.

**DMA arbiter FSM**, states IDLE and REQ:
- IDLE → REQ when any `pend` is set. The grant goes to the first set `pend` strictly after `last` (modulo `NUM_EP`). `dma_ep` is registered.
- REQ: `dma_req=1`.
- REQ → IDLE on `dma_ack`; then `last = dma_ep`.
- REQ → IDLE without ack if `pend[dma_ep]` drops (because `dma_en` was cleared).

## Timing
- Reset values:
  - `csr`, INT enables, `int_stat`, `pend` = 0.
  - `buf0`, `buf1`, `buf0_orig` = `32'hFFFF_FFFF`.
  - `ep_hit`, `ep_idx`, `inta`, `intb`, `dma_req`, `dma_ep` = 0.
  - FSM = IDLE; `last` = `NUM_EP-1`.
- `ep_sel` to `ep_hit` / `ep_idx`: 1 cycle.
- Internal update strobes must be issued no earlier than the cycle after `ep_sel` becomes valid.
- `int_set` to `int_stat`: 1 edge; to `inta` / `intb`: 2 edges.
- Register write to `dout`: visible on the next cycle.
- `pend` set to `dma_req` high: 2 cycles.
- There is at least one IDLE cycle between grants.
- `dma_ack` asserted in the same cycle `dma_req` rises is honoured.
- `dma_ack` while IDLE is ignored.
- Reset asserted mid-REQ returns the FSM to IDLE and drops `dma_req` asynchronously.

## Configuration
- `USBF_EP_DMA_EN` defined: pending flags and the arbiter FSM are built as described.
- Not defined:
  - `dma_req` and `dma_ep` are tied to 0 and `dma_ack` is ignored.
  - CSR[15] remains read/write storage with no effect.

## Structure
- Package `usbf_ep_pkg` holds:
  - register offset constants;
  - CSR field positions;
  - type encodings;
  - interrupt bit indices;
  - the arbiter state enum.
- One sub-module, `usbf_ep_dma_arb`, contains the round-robin grant logic and the FSM. It takes `pend` and `dma_ack` and returns `dma_req`, `dma_ep` and an ack pulse.

## Test plan
- Reset, then read all registers → BUF0/BUF1 read `FFFF_FFFF`; CSR and INT read 0; `inta`, `intb`, `dma_req` are 0.
- EP1 and EP2 both have CSR `number=5`, type=OUT; drive `ep_sel=5` → next cycle `ep_hit=1`, `ep_idx=1`.
- EP0 with `iena=6'h08`; pulse `int_set[4]` → `inta=1` two edges later. Read INT and pulse `int_set[0]` on the same edge → `int_stat` reads `7'h01`.
- Write BUF0=`0x1234_5678`; `buf0_set` with `idin=0`; then `buf0_rl` → BUF0 reads `0x1234_5678`. A same-cycle register write and `buf0_set` → the written value wins.
- (DMA build) `dma_en=1` on EP0 and EP3; `buf0_set` on both → grants EP0 then EP3, acked, with exactly one IDLE cycle between them. Re-pend EP3 → EP3 is granted again.
- (DMA build) Clear `dma_en` while in REQ → `dma_req` falls without ack and the FSM returns to IDLE.
